// File: rtl/cnn1d_pkg.sv
// Shared numeric format for the 1-D CNN datapath: signed fixed point, 9 fractional bits.
package cnn1d_pkg;
   localparam int DATA_WIDTH = 12;
   localparam int FRAC_BITS  = 9;
endpackage

// File: rtl/xor_net_seq.sv
// Sequences one xor_net sample at a time: accept, settle NET_LATENCY+1 cycles, capture and threshold.
// Result valid NET_LATENCY+1 edges after accept; in_ready stays low until the result is taken or clr.
module xor_net_seq #(
   parameter int                    DATA_WIDTH  = cnn1d_pkg::DATA_WIDTH,
   parameter int                    NET_LATENCY = 4,
   parameter logic [DATA_WIDTH-1:0] THRESHOLD   = DATA_WIDTH'('h100),
   parameter int                    COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_a,
   input  logic [DATA_WIDTH-1:0]  in_b,
   output logic [DATA_WIDTH-1:0]  net_a,
   output logic [DATA_WIDTH-1:0]  net_b,
   input  logic [DATA_WIDTH-1:0]  net_o,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_o,
   output logic                   out_bit,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] sample_count
);

   localparam int CNT_W = (NET_LATENCY < 1) ? 1 : $clog2(NET_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      OUT    = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   in_ready_d, out_valid_d;
   logic [DATA_WIDTH-1:0]  net_a_d, net_b_d, out_o_d;
   logic [COUNT_WIDTH-1:0] count_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         in_ready     <= 1'b0;
         net_a        <= '0;
         net_b        <= '0;
         out_valid    <= 1'b0;
         out_o        <= '0;
         sample_count <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         in_ready     <= in_ready_d;
         net_a        <= net_a_d;
         net_b        <= net_b_d;
         out_valid    <= out_valid_d;
         out_o        <= out_o_d;
         sample_count <= count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready;
      net_a_d     = net_a;
      net_b_d     = net_b;
      out_valid_d = out_valid;
      out_o_d     = out_o;
      count_d     = sample_count;

      // clr pre-empts any handshake in flight; operands and result are left in place
      if (clr) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         in_ready_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_d = 1'b1;
               if (in_valid && in_ready) begin
                  net_a_d    = in_a;
                  net_b_d    = in_b;
                  cnt_d      = CNT_W'(NET_LATENCY);
                  in_ready_d = 1'b0;
                  state_d    = SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  out_o_d     = net_o;
                  out_valid_d = 1'b1;
                  state_d     = OUT;
               end
            end
            OUT: begin
               if (out_valid && out_ready) begin
                  out_valid_d = 1'b0;
                  count_d     = sample_count + COUNT_WIDTH'(1);
                  in_ready_d  = 1'b1;
                  state_d     = IDLE;
               end
            end
            default: begin
               state_d    = IDLE;
               in_ready_d = 1'b1;
            end
         endcase
      end
   end

   assign out_bit = ($signed(out_o) >= $signed(THRESHOLD));
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_xor_net_seq.sv
// Directed bench for xor_net_seq: a driver pushes hand-computed results, a monitor pops them on each new out_valid.
module tb_xor_net_seq;
   localparam int DW = 12;
   localparam int NL = 4;
   localparam int CW = 4;

   typedef struct {
      logic [DW-1:0] o;
      logic          ebit;
      int            acc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   logic          clk = 1'b0, rst = 1'b1, clr = 1'b0;
   logic          in_valid = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] in_a = '0, in_b = '0;
   logic          in_ready, out_valid, out_bit, busy;
   logic [DW-1:0] net_a, net_b, net_o, out_o;
   logic [CW-1:0] sample_count;

   logic          force_en = 1'b0;
   logic [DW-1:0] force_val = '0;
   logic [DW-1:0] pipe [NL];

   // zero-latency instance
   logic          in0_valid = 1'b0, out0_ready = 1'b0;
   logic [DW-1:0] in0_a = '0, in0_b = '0;
   logic          in0_ready, out0_valid, out0_bit, busy0;
   logic [DW-1:0] net0_a, net0_b, net0_o, out0_o;
   logic [15:0]   count0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   xor_net_seq #(.DATA_WIDTH(DW), .NET_LATENCY(NL), .THRESHOLD(12'h100), .COUNT_WIDTH(CW)) u_dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .net_a(net_a), .net_b(net_b), .net_o(net_o),
      .out_valid(out_valid), .out_ready(out_ready), .out_o(out_o), .out_bit(out_bit),
      .busy(busy), .sample_count(sample_count)
   );

   xor_net_seq #(.DATA_WIDTH(DW), .NET_LATENCY(0)) u_dut0 (
      .clk(clk), .rst(rst), .clr(1'b0),
      .in_valid(in0_valid), .in_ready(in0_ready), .in_a(in0_a), .in_b(in0_b),
      .net_a(net0_a), .net_b(net0_b), .net_o(net0_o),
      .out_valid(out0_valid), .out_ready(out0_ready), .out_o(out0_o), .out_bit(out0_bit),
      .busy(busy0), .sample_count(count0)
   );

   function automatic logic [DW-1:0] xor_model(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return ((a == 12'h200) != (b == 12'h200)) ? 12'h200 : 12'h000;
   endfunction

   // behavioural xor_net with a 4-cycle pipeline
   always @(posedge clk) begin
      pipe[0] <= xor_model(net_a, net_b);
      for (int i = 1; i < NL; i++) pipe[i] <= pipe[i-1];
   end
   assign net_o  = force_en ? force_val : pipe[NL-1];
   assign net0_o = net0_a + net0_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   logic ov_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && !ov_prev) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_result", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_out_o", 32'(out_o), 32'(e.o));
            chk("sb_out_bit", 32'(out_bit), 32'(e.ebit));
            chk("sb_latency", 32'(cyc - e.acc), 32'(NL + 1));
         end
      end
      ov_prev = out_valid;
   end

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] eo, input logic eb, input bit push);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
      end else begin
         if (push) sb_q.push_back('{o: eo, ebit: eb, acc: cyc + 1});
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || out_valid) && n < 100);
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_net_a"}, 32'(net_a), 32'd0);
      chk({tag, "_net_b"}, 32'(net_b), 32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_o"}, 32'(out_o), 32'd0);
      chk({tag, "_out_bit"}, 32'(out_bit), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_count"}, 32'(sample_count), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values and release
      #1 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_reset_vals("rst");
      end
      rst = 1'b1;
      #1 chk("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("rel_in_ready_after_edge", 32'(in_ready), 32'd1);

      // XOR truth table, back-to-back
      out_ready = 1'b1;
      send(12'h000, 12'h000, 12'h000, 1'b0, 1'b1);
      send(12'h200, 12'h000, 12'h200, 1'b1, 1'b1);
      send(12'h000, 12'h200, 12'h200, 1'b1, 1'b1);
      send(12'h200, 12'h200, 12'h000, 1'b0, 1'b1);
      wait_idle();
      chk("xor_count", 32'(sample_count), 32'd4);

      // backpressure with new input pending
      out_ready = 1'b0;
      send(12'h200, 12'h000, 12'h200, 1'b1, 1'b1);
      wait_valid();
      in_valid = 1'b1;
      in_a     = 12'h123;
      in_b     = 12'h456;
      repeat (10) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_o", 32'(out_o), 32'h200);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_net_a", 32'(net_a), 32'h200);
         chk("bp_net_b", 32'(net_b), 32'h000);
         chk("bp_count", 32'(sample_count), 32'd4);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_count_after", 32'(sample_count), 32'd5);
      chk("bp_out_valid_after", 32'(out_valid), 32'd0);
      chk("bp_in_ready_after", 32'(in_ready), 32'd1);

      // threshold boundary
      force_en  = 1'b1;
      force_val = 12'h100;
      send(12'h001, 12'h002, 12'h100, 1'b1, 1'b1);
      wait_idle();
      force_val = 12'h0FF;
      send(12'h001, 12'h002, 12'h0FF, 1'b0, 1'b1);
      wait_idle();
      force_val = 12'hF00;
      send(12'h001, 12'h002, 12'hF00, 1'b0, 1'b1);
      wait_idle();
      force_en = 1'b0;
      chk("thr_count", 32'(sample_count), 32'd8);

      // clr during SETTLE
      send(12'h200, 12'h200, 12'h000, 1'b0, 1'b0);
      @(negedge clk);
      chk("clr_settle_busy_before", 32'(busy), 32'd1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_settle_busy", 32'(busy), 32'd0);
      chk("clr_settle_in_ready", 32'(in_ready), 32'd1);
      chk("clr_settle_net_a", 32'(net_a), 32'h200);
      chk("clr_settle_net_b", 32'(net_b), 32'h200);
      repeat (8) @(negedge clk);
      chk("clr_settle_no_valid", 32'(out_valid), 32'd0);
      chk("clr_settle_count", 32'(sample_count), 32'd8);

      // clr together with out_ready in OUT
      out_ready = 1'b0;
      send(12'h000, 12'h200, 12'h200, 1'b1, 1'b1);
      wait_valid();
      clr       = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_out_valid", 32'(out_valid), 32'd0);
      chk("clr_out_busy", 32'(busy), 32'd0);
      chk("clr_out_in_ready", 32'(in_ready), 32'd1);
      chk("clr_out_count", 32'(sample_count), 32'd8);
      chk("clr_out_out_o", 32'(out_o), 32'h200);
      chk("clr_out_net_a", 32'(net_a), 32'h000);
      chk("clr_out_net_b", 32'(net_b), 32'h200);

      // asynchronous reset in OUT
      out_ready = 1'b0;
      send(12'h200, 12'h000, 12'h200, 1'b1, 1'b1);
      wait_valid();
      #2 rst = 1'b0;
      #1 chk_reset_vals("arst");
      @(negedge clk);
      rst = 1'b1;
      #1 chk("arst_rel_in_ready_before", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("arst_rel_in_ready_after", 32'(in_ready), 32'd1);

      // 4-bit count wrap over 17 transactions
      out_ready = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         send(12'h000, 12'h000, 12'h000, 1'b0, 1'b1);
         wait_idle();
         chk("wrap_count", 32'(sample_count), 32'(i % 16));
      end

      // NET_LATENCY = 0: capture one edge after accept
      out0_ready = 1'b1;
      @(negedge clk);
      chk("nl0_in_ready", 32'(in0_ready), 32'd1);
      in0_valid = 1'b1;
      in0_a     = 12'h050;
      in0_b     = 12'h060;
      @(negedge clk);
      in0_valid = 1'b0;
      chk("nl0_busy_e0", 32'(busy0), 32'd1);
      chk("nl0_valid_e0", 32'(out0_valid), 32'd0);
      @(negedge clk);
      chk("nl0_valid_e1", 32'(out0_valid), 32'd1);
      chk("nl0_out_o", 32'(out0_o), 32'h0B0);
      chk("nl0_out_bit", 32'(out0_bit), 32'd0);
      @(negedge clk);
      chk("nl0_busy_e2", 32'(busy0), 32'd0);
      chk("nl0_count", 32'(count0), 32'd1);
      in0_valid = 1'b1;
      in0_a     = 12'h100;
      in0_b     = 12'h010;
      @(negedge clk);
      in0_valid = 1'b0;
      @(negedge clk);
      chk("nl0_out_o_2", 32'(out0_o), 32'h110);
      chk("nl0_out_bit_2", 32'(out0_bit), 32'd1);
      @(negedge clk);
      chk("nl0_count_2", 32'(count0), 32'd2);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
